// File: rtl/uart_byte_tx.sv
// uart_byte_tx - UART serializer for the command parser's byte interface.
//
// Accepts one byte per tx_start_i/tx_ready_o handshake and sends it LSB-first
// as: start bit (0), DATA_BITS data bits, optional parity bit, and STOP_BITS
// stop bits (1). Every bit lasts CLKS_PER_BIT clock cycles.
//
// Handshake: a byte is accepted on a clk edge where tx_start_i=1 and
// tx_ready_o=1. tx_data_i is sampled on that edge only. tx_ready_o stays low
// for the whole frame and rises on the last edge of the final stop bit.
// tx_start_i is ignored, not queued, while tx_ready_o=0.
//
// Optional feature: define UART_TX_PARITY_EN to add a parity bit after the
// data bits. This also adds the parameter PARITY_ODD (0 = even, 1 = odd).
//
// Ports:
//   clk         system clock
//   rstn        asynchronous active-low reset
//   tx_start_i  request to send (sampled only while tx_ready_o=1)
//   tx_data_i   byte to send (bits above DATA_BITS-1 are ignored)
//   tx_ready_o  1 = idle and able to accept a byte
//   tx_o        serial line, idle high
//   tx_busy_o   registered inverse of tx_ready_o (debug LED)
//   dbg_state   current FSM state, for debug and checkers
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_o,
    output logic       tx_busy_o,
    output logic [2:0] dbg_state
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_n;
    logic [CNT_W-1:0]       cnt_q, cnt_n;      // baud counter
    logic [2:0]             idx_q, idx_n;      // data bit index, then stop bit index
    logic [DATA_BITS-1:0]   shreg_q, shreg_n;
    logic                   tx_q, tx_n;
    logic                   ready_q, ready_n;
    logic                   busy_q, busy_n;
    logic                   wrap;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_n;      // parity of the accepted byte
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            shreg_q <= shreg_n;
            tx_q    <= tx_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    // Next-state logic. tx_n always holds the value the line carries for the
    // bit that begins on the coming edge, so tx_o stays a plain register.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        shreg_n = shreg_q;
        tx_n    = tx_q;
        ready_n = ready_q;
        busy_n  = busy_q;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        wrap    = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_n = wrap ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (tx_start_i && ready_q) begin
                    shreg_n = tx_data_i[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
                    par_n   = (^tx_data_i[DATA_BITS-1:0]) ^ PARITY_ODD;
`endif
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = 1'b0;
                    ready_n = 1'b0;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (wrap) begin
                    tx_n    = shreg_q[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    if (idx_q == DATA_LAST) begin
                        idx_n   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_n    = par_q;
                        state_n = PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = STOP;
`endif
                    end else begin
                        idx_n   = idx_q + 3'd1;
                        shreg_n = shreg_q >> 1;
                        tx_n    = shreg_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (wrap) begin
                    tx_n    = 1'b1;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (wrap) begin
                    if (idx_q == STOP_LAST) begin
                        idx_n   = '0;
                        ready_n = 1'b1;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                idx_n   = '0;
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = ready_q;
    assign tx_busy_o  = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx - self-checking bench for uart_byte_tx at CLKS_PER_BIT=4.
//
// A frame-level reference model turns each accepted byte into the list of
// line levels it must produce and expands that list to one entry per clock.
// A compare process checks {tx_ready_o, tx_busy_o, tx_o} against the model
// on every falling edge. Directed tests add literal expectations (bit
// sequences, frame lengths, gaps, reset behaviour), and a random phase
// drives start pulses, held levels and changing data.
module tb_uart_byte_tx;

    localparam int N  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam logic [2:0] IDLE_EXP = 3'b101;  // {ready, busy, tx}

    logic       clk;
    logic       rstn;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready_o;
    logic       tx_o;
    logic       tx_busy_o;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    uart_byte_tx #(
        .CLKS_PER_BIT(N),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .tx_start_i(tx_start),
        .tx_data_i (tx_data),
        .tx_ready_o(tx_ready_o),
        .tx_o      (tx_o),
        .tx_busy_o (tx_busy_o),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Line levels of one frame, index 0 first on the wire.
    function automatic logic [FB-1:0] frame_bits(input logic [7:0] d);
        logic [FB-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    logic [2:0] exp_q[$];
    logic [2:0] cur_exp = IDLE_EXP;

    // A byte is taken when the model says the block was ready before the edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q.delete();
            cur_exp = IDLE_EXP;
        end else begin
            if (cur_exp[2] && tx_start) begin
                logic [FB-1:0] fb;
                fb = frame_bits(tx_data);
                for (int b = 0; b < FB; b++)
                    for (int c = 0; c < N; c++)
                        exp_q.push_back({1'b0, 1'b1, fb[b]});
            end
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            else                  cur_exp = IDLE_EXP;
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (check_en) begin
            n_checks++;
            if ({tx_ready_o, tx_busy_o, tx_o} === cur_exp) n_pass++;
            else $display("FAIL cycle_compare t=%0t: {ready,busy,tx} got %b expected %b",
                          $time, {tx_ready_o, tx_busy_o, tx_o}, cur_exp);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Waits (bounded) for tx_ready_o low, then records the line at the
    // second cycle of every bit and counts the cycles ready stays low.
    task automatic capture_frame(output logic [FB-1:0] bits, output int low_cycles);
        int guard;
        guard      = 0;
        bits       = '1;
        low_cycles = 0;
        while (tx_ready_o !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_fall", int'(tx_ready_o), 0);
        while (tx_ready_o === 1'b0 && low_cycles < 200) begin
            if (low_cycles % N == 1 && low_cycles / N < FB) bits[low_cycles / N] = tx_o;
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_ready_low();
        int guard;
        guard = 0;
        while (tx_ready_o !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_low_wait", int'(tx_ready_o), 0);
    endtask

    task automatic send_pulse(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [FB-1:0] bits;
        int            low;
        int            cyc;
        int            rises;
        int            gap;
        logic          prev;
        bit            hold;
        logic [FB-1:0] lit_a;
        logic [FB-1:0] lit_0;

`ifdef UART_TX_PARITY_EN
        lit_a = 11'b10010000010;
        lit_0 = 11'b10001100000;
`else
        lit_a = 10'b1010000010;
        lit_0 = 10'b1001100000;
`endif

        rstn     = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        #3 rstn  = 1'b0;
        #1 check_en = 1'b1;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;

        // Model pinned to hand-computed frames.
        check("model_frame_41", int'(frame_bits(8'h41)), int'(lit_a));
        check("model_frame_30", int'(frame_bits(8'h30)), int'(lit_0));

        // Idle 100 cycles with no request.
        repeat (100) @(negedge clk);
        check("idle_tx", int'(tx_o), 1);
        check("idle_ready", int'(tx_ready_o), 1);
        check("idle_busy", int'(tx_busy_o), 0);

        // "A" with a single-cycle start pulse.
        send_pulse(8'h41);
        capture_frame(bits, low);
        check("A_bits", int'(bits), int'(lit_a));
        check("A_ready_low_cycles", low, FB * N);
        repeat (5) @(negedge clk);

        // "0" with start held until ready falls.
        tx_data  = 8'h30;
        tx_start = 1'b1;
        wait_ready_low();
        tx_start = 1'b0;
        capture_frame(bits, low);
        check("zero_bits", int'(bits), int'(lit_0));
        check("zero_ready_low_cycles", low, FB * N);
        repeat (5) @(negedge clk);

        // Back-to-back "1","0", start held high throughout; data changes mid-frame.
        tx_data  = 8'h31;
        tx_start = 1'b1;
        wait_ready_low();
        cyc   = 1;
        prev  = 1'b0;
        rises = 0;
        gap   = 0;
        while (rises < 2 && cyc < 300) begin
            @(negedge clk);
            if (tx_ready_o === 1'b1 && prev === 1'b0) rises++;
            prev = tx_ready_o;
            if (rises < 2) begin
                cyc++;
                if (tx_ready_o === 1'b1) gap++;
            end
            if (cyc == 20) tx_data = 8'h30;
        end
        tx_start = 1'b0;
        check("b2b_total_cycles", cyc, 2 * FB * N + 1);
        check("b2b_idle_gap", gap, 1);
        repeat (5) @(negedge clk);

        // Reset pulled mid-frame, then a clean frame.
        send_pulse(8'h55);
        repeat (16) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_tx", int'(tx_o), 1);
        check("rst_mid_ready", int'(tx_ready_o), 1);
        check("rst_mid_busy", int'(tx_busy_o), 0);
        check("rst_mid_state", int'(dbg_state), 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        send_pulse(8'h41);
        capture_frame(bits, low);
        check("post_rst_bits", int'(bits), int'(lit_a));
        check("post_rst_low_cycles", low, FB * N);

        // Random phase: sparse pulses, held levels and data changing every cycle.
        hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i % 500 == 0) hold = ($urandom_range(0, 1) == 1);
            tx_start = hold ? 1'b1 : ($urandom_range(0, 7) == 0);
            tx_data  = 8'($urandom_range(0, 255));
        end
        tx_start = 1'b0;
        repeat (2 * FB * N) @(negedge clk);
        check("final_ready", int'(tx_ready_o), 1);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- UART serializer at the transmit end of the command parser's byte interface (tx_start/tx_data/tx_ready).
- Accepts one byte per handshake and shifts it out LSB-first on the board serial line: start bit, data bits, optional parity bit, stop bit(s).
- Holds tx_ready_o low for the whole frame, so the parser's wait-for-ready-low / wait-for-ready-high sequencing works unchanged.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8; upper bits of tx_data_i ignored.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- tx_start_i  input  1  request to send; sampled only when tx_ready_o=1
- tx_data_i  input  8  byte to send; captured on the accepting cycle
- tx_ready_o  output  1  1 = idle and able to accept a byte
- tx_o  output  1  serial line, idle high
- tx_busy_o  output  1  registered inverse of tx_ready_o (drives a debug LED)

Behaviour:
- Interface decided: one clock; reset is asynchronous and active-low; ports named clk and rstn.
- Reset values: tx_o=1, tx_ready_o=1, tx_busy_o=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: tx_o returns high immediately (asynchronously) and the frame is abandoned; no partial-frame resume.
- State machine states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - Acceptance: on a clk edge where tx_start_i=1 and tx_ready_o=1, the block latches tx_data_i[DATA_BITS-1:0] into a shift register.
  - On that same edge: tx_ready_o<=0, tx_busy_o<=1, tx_o<=0, go to START.
  - tx_start_i held high across many cycles produces exactly one frame per acceptance. A level still high when ready returns starts a new frame. Single-cycle pulses and held levels are both legal.
- Bit timing: a baud counter, width clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1. Every bit is held exactly CLKS_PER_BIT cycles; the bit boundary is at counter wrap.
- START: after CLKS_PER_BIT cycles, drive data bit 0 and go to DATA.
- DATA:
  - Shift LSB-first.
  - A bit index counter 0..DATA_BITS-1 advances at each wrap.
  - After the last data bit, go to PARITY (macro on) or STOP with tx_o=1.
- STOP: tx_o=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: tx_ready_o<=1, tx_busy_o<=0, go to IDLE.
- Frame length (ready low): (1+DATA_BITS+STOP_BITS[+1 parity])*CLKS_PER_BIT cycles. Default = 10*434 = 4340 cycles.
- Back-to-back frames:
  - If tx_start_i=1 on the first cycle tx_ready_o=1, the next start bit begins on the following edge.
  - Minimum idle gap is one clk cycle; no extra idle bit is inserted.
- tx_data_i changes while tx_ready_o=0 have no effect on the frame in progress.
- tx_start_i while busy is ignored; it is not queued.
- All outputs are registered; tx_o has no combinational path from any input.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0).
  - PARITY state emits one bit after the data bits: XOR of the latched data bits (even parity), inverted when PARITY_ODD=1.
  - Frame grows by one bit time.
- Undefined: no PARITY state, no PARITY_ODD parameter, frame is 8N1 / 8N2.

Test Plan:
- Reset, then idle 100 cycles with tx_start_i=0 -> tx_o=1, tx_ready_o=1, tx_busy_o=0 throughout.
- CLKS_PER_BIT=4, send 8'h41 ("A") with a one-cycle start pulse:
  - tx_ready_o falls on the next edge and stays low 40 cycles.
  - tx_o sequence per 4-cycle bit: 0,1,0,0,0,0,0,1,0,1.
- CLKS_PER_BIT=4, tx_start_i held high until tx_ready_o falls (parser S1 style), then low; data "0"=8'h30 -> exactly one frame, bits 0,0,0,0,0,1,1,0,0,1.
- Back-to-back "1","0", start held high continuously:
  - two frames, one idle cycle between stop and second start bit, total 81 cycles.
  - tx_data_i changed mid-frame does not corrupt frame 1.
- Assert rstn low at cycle 17 of a frame -> tx_o=1 and tx_ready_o=1 before the next clk edge; the next request sends a full clean frame.
- With UART_TX_PARITY_EN, PARITY_ODD=0:
  - 8'h41 -> parity bit 0, frame 44 cycles at CLKS_PER_BIT=4.
  - PARITY_ODD=1 -> parity bit 1.
